// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: counts clk_i cycles per reference window and checks the result against a range
module clk_freq_monitor #(
  parameter int CntWidth      = 16,
  parameter int NumRefPeriods = 1,
  parameter int SyncStages    = 2,
  parameter int LockCount     = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                rt_clk_i,
  input  logic [CntWidth-1:0] thr_lo_i,
  input  logic [CntWidth-1:0] thr_hi_i,
  output logic [CntWidth-1:0] meas_o,
  output logic                meas_valid_o,
  output logic                in_range_o,
  output logic                lock_o,
  output logic                timeout_o,
  output logic                err_o
);
  localparam int EW = $clog2(NumRefPeriods + 1);
  localparam int LW = $clog2(LockCount + 1);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2;
  logic [SyncStages-1:0] sync_q;
  logic                  sync_prev;
  logic [SyncStages:0]   vld_q;
  logic [1:0]            state;
  logic [CntWidth-1:0]   cnt, meas_next;
  logic [EW-1:0]         edge_cnt;
  logic [LW-1:0]         lock_cnt, lock_inc;
  logic                  ep, close_w, sat, in_rng;
  // Resynchronise rt_clk_i; vld_q marks when the whole edge history holds real samples,
  // so a reference clock that is already high at reset release gives no false edge.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      vld_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SyncStages-2:0], rt_clk_i};
      sync_prev <= sync_q[SyncStages-1];
      vld_q     <= {vld_q[SyncStages-1:0], 1'b1};
    end
  // Window events: closing edge, counter saturation, saturating result and range check
  always_comb begin
    ep        = vld_q[SyncStages] & sync_q[SyncStages-1] & ~sync_prev;
    close_w   = (state == MEAS) && ep && (edge_cnt == EW'(NumRefPeriods - 1));
    sat       = (state == MEAS) && (cnt == '1) && !close_w;
    meas_next = (cnt == '1) ? cnt : cnt + CntWidth'(1);
    in_rng    = (thr_lo_i <= meas_next) && (meas_next <= thr_hi_i);
    lock_inc  = (lock_cnt == LW'(LockCount)) ? lock_cnt : lock_cnt + LW'(1);
  end
  // Measurement FSM: a closing edge reopens the next window immediately
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      edge_cnt     <= '0;
      lock_cnt     <= '0;
      meas_o       <= '0;
      meas_valid_o <= 1'b0;
      in_range_o   <= 1'b0;
      lock_o       <= 1'b0;
      timeout_o    <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
      err_o        <= 1'b0;
      if (!en_i) begin
        state      <= IDLE;
        cnt        <= '0;
        edge_cnt   <= '0;
        lock_cnt   <= '0;
        lock_o     <= 1'b0;
        in_range_o <= 1'b0;
      end else if (state == IDLE) begin
        state <= ARM;
      end else if (state == ARM) begin
        if (ep) begin
          state    <= MEAS;
          cnt      <= '0;
          edge_cnt <= '0;
        end
      end else if (state != MEAS) begin
        state <= IDLE;
      end else if (close_w) begin
        meas_o       <= meas_next;
        meas_valid_o <= 1'b1;
        in_range_o   <= in_rng;
        lock_cnt     <= in_rng ? lock_inc : '0;
        lock_o       <= in_rng && (lock_inc >= LW'(LockCount));
        err_o        <= !in_rng && lock_o;
        cnt          <= '0;
        edge_cnt     <= '0;
      end else if (sat) begin
        timeout_o  <= 1'b1;
        err_o      <= lock_o;
        lock_o     <= 1'b0;
        lock_cnt   <= '0;
        in_range_o <= 1'b0;
        state      <= ARM;
        cnt        <= '0;
        edge_cnt   <= '0;
      end else begin
        cnt      <= cnt + CntWidth'(1);
        edge_cnt <= edge_cnt + EW'(ep);
      end
    end
endmodule
